// File: rtl/sop_table_unit_if.sv
// Bundle for the programmable sum-of-products table unit:
// config writes, evaluation handshake and scan results.
interface sop_table_unit_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  logic                      cfg_we;
  logic [N_IN-1:0]           cfg_addr;
  logic [N_OUT-1:0]          cfg_wdata;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN-1:0]           in_vec;
  logic                      out_valid;
  logic [N_OUT-1:0]          out_f;
  logic                      scan_start;
  logic                      scan_busy;
  logic                      scan_done;
  logic [N_OUT*(N_IN+1)-1:0] scan_count;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    output in_valid,
    output in_vec,
    output scan_start,
    input  in_ready,
    input  out_valid,
    input  out_f,
    input  scan_busy,
    input  scan_done,
    input  scan_count
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    input  in_valid,
    input  in_vec,
    input  scan_start,
    output in_ready,
    output out_valid,
    output out_f,
    output scan_busy,
    output scan_done,
    output scan_count
  );
endinterface

// File: rtl/sop_table_unit.sv
// Programmable truth table for N_OUT functions of N_IN inputs,
// with handshaked evaluation and a true-minterm count scan.
module sop_table_unit #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input logic              clk,
  input logic              rst_n,
  sop_table_unit_if.slave  bus
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_OUT-1:0] tbl_q [DEPTH];
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [CW-1:0]    cnt_q [N_OUT];
  logic [CW-1:0]    cnt_d [N_OUT];
  logic             ov_q, ov_d;
  logic [N_OUT-1:0] f_q, f_d;

  logic ready;
  logic accept;
  logic wr_en;

  // Table is frozen while scanning so counts see a stable snapshot
  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign accept = bus.in_valid && ready;
  assign wr_en  = bus.cfg_we && ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.scan_start) begin
          state_d = SCAN;
          idx_d   = '0;
          for (int k = 0; k < N_OUT; k++) begin
            cnt_d[k] = '0;
          end
        end
      end
      SCAN: begin
        for (int k = 0; k < N_OUT; k++) begin
          cnt_d[k] = cnt_q[k] + CW'(tbl_q[idx_q][k]);
        end
        idx_d = idx_q + N_IN'(1);
        if (&idx_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read happens before the same-edge write, so collisions return old data
  always_comb begin
    ov_d = accept;
    f_d  = f_q;
    if (accept) begin
      f_d = tbl_q[bus.in_vec];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      f_q     <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < DEPTH; m++) begin
        tbl_q[m] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = ov_q;
  assign bus.out_f     = f_q;
  assign bus.scan_busy = (state_q == SCAN);
  assign bus.scan_done = (state_q == DONE);

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    assign bus.scan_count[k*CW +: CW] = cnt_q[k];
  end

endmodule

// File: doc/sop_table_unit.md
Name: sop_table_unit

Overview:
- Programmable, parametrised successor to the fixed sum-of-products blocks.
- Holds a truth table for N_OUT Boolean functions of N_IN inputs; the table is written through a config port.
- Evaluates input vectors through a valid/ready handshake with a registered, 1-cycle-latency result.
- A scan engine walks all 2^N_IN minterms and reports the number of true minterms per function. Lab datapaths use it in place of hard-wired SOP logic.

Parameters:
N_IN, 4, number of function inputs; table depth is 2^N_IN entries.
N_OUT, 2, number of functions; table width in bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  N_IN  minterm index to write
cfg_wdata  input  N_OUT  function values for that minterm; bit k belongs to function k
in_valid  input  1  evaluation request
in_ready  output  1  unit can accept a request
in_vec  input  N_IN  input vector; bit 0 is the LSB of the minterm index
out_valid  output  1  result valid; single-cycle pulse per accepted request
out_f  output  N_OUT  function values for the accepted vector
scan_start  input  1  start minterm-count scan
scan_busy  output  1  scan in progress
scan_done  output  1  single-cycle pulse when counts are final
scan_count  output  N_OUT*(N_IN+1)  per-function true-minterm count; function k occupies slice [k*(N_IN+1) +: N_IN+1]

Behaviour:
- Reset (async assert, sync-released use):
  - All table entries = 0; FSM = IDLE.
  - out_valid=0, out_f=0, scan_busy=0, scan_done=0, scan_count=0, internal index=0.
- Table: 2^N_IN x N_OUT register array.
  - Write occurs on the clk edge when cfg_we=1 and state is IDLE or DONE.
  - cfg_we during SCAN is dropped, with no deferred write.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on scan_start=1; counters and index clear on that edge.
  - SCAN: each cycle reads entry[index] and adds bit k to count k. When index = 2^N_IN-1, the FSM moves to DONE with the final accumulation applied.
  - DONE: scan_done=1 for exactly one cycle, then IDLE.
  - A scan takes 2^N_IN cycles in SCAN, and scan_done is asserted on cycle 2^N_IN+1 after the start edge.
- scan_busy = (state==SCAN).
- scan_start is ignored in SCAN and DONE.
- scan_count holds its value from completion until the next accepted scan_start. Mid-scan values are partial and undefined for consumers.
- Count width N_IN+1 holds the full range 0..2^N_IN without overflow.
- in_ready = (state==IDLE || state==DONE), combinational from state only.
- Handshake: a request is accepted when in_valid && in_ready.
  - On the next cycle: out_valid=1 and out_f = table[in_vec] as read at the accept edge.
  - With no accept, out_valid=0 and out_f holds its last value.
  - There is no output backpressure. Back-to-back accepts give back-to-back results.
- Read-before-write: if cfg_we and an accepted request address the same entry in the same cycle, out_f carries the old value.
- scan_start and an accepted request in the same IDLE cycle: both take effect. The result appears on the next cycle while scan_busy=1.
- in_valid while SCAN: not accepted; the requester must hold in_valid until in_ready.
- Reset mid-scan: immediate abort. Counts, table and index all return to 0, and no scan_done pulse is produced.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> all outputs 0, in_ready=1; evaluating in_vec=4'hA -> out_f=0 one cycle later.
- Program f0 = minterms {0,2,8,10,4,6} and f1 = {0,2,4} (N_IN=4, N_OUT=2), then evaluate all 16 vectors back-to-back -> out_valid high 16 consecutive cycles. Vector 0 gives out_f=2'b11, vector 8 gives 2'b01, vector 5 gives 2'b00.
- Scan after that programming:
  - scan_start pulse -> scan_busy high exactly 16 cycles.
  - scan_done pulse on the 17th cycle.
  - scan_count slice0=6, slice1=3; values held until the next scan.
- All-ones table scan -> each count = 16 (5'b10000), with no wrap.
- Collision and lockout:
  - Same-cycle cfg_we to addr 3 (data 2'b11, old 2'b00) plus eval of vector 3 -> out_f=2'b00; re-evaluating gives 2'b11.
  - cfg_we during SCAN is dropped, and the table is unchanged on read-back.
  - in_valid during SCAN sees in_ready=0 and is accepted in the DONE cycle.
- Reset mid-scan: rst_n low at scan cycle 7 -> scan_busy=0 and scan_count=0 immediately; no scan_done pulse; all table entries read 0.
